// File: rtl/pio_shift_engine.sv
// ISR/OSR shift unit for the PIO state machine: IN/OUT/PUSH/PULL with autopush/autopull.
// Define PIO_SHIFT_MOV_EN to add the MOV_ISR/MOV_OSR datapath.
module pio_shift_engine #(
    parameter int DATA_W = 32,
    localparam int CNT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [2:0]        cmd,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic              cmd_block,
    input  logic              cmd_cond,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] x_in,
    input  logic              cfg_in_right,
    input  logic              cfg_out_right,
    input  logic              cfg_autopush,
    input  logic              cfg_autopull,
    input  logic [CNT_W-1:0]  cfg_push_thresh,
    input  logic [CNT_W-1:0]  cfg_pull_thresh,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              stall,
    output logic [DATA_W-1:0] isr,
    output logic [DATA_W-1:0] osr,
    output logic [CNT_W:0]    isr_count,
    output logic [CNT_W:0]    osr_count
);

    localparam logic [CNT_W:0] FULL = (CNT_W+1)'(DATA_W);
    localparam logic [2:0] CMD_IN   = 3'd1;
    localparam logic [2:0] CMD_OUT  = 3'd2;
    localparam logic [2:0] CMD_PUSH = 3'd3;
    localparam logic [2:0] CMD_PULL = 3'd4;
`ifdef PIO_SHIFT_MOV_EN
    localparam logic [2:0] CMD_MOV_ISR = 3'd5;
    localparam logic [2:0] CMD_MOV_OSR = 3'd6;
`endif

    logic [DATA_W-1:0] isr_q, isr_d, osr_q, osr_d;
    logic [CNT_W:0]    isr_cnt_q, isr_cnt_d, osr_cnt_q, osr_cnt_d;

    logic [CNT_W:0]    n, t_push, t_pull, isr_cnt_inc, osr_cnt_inc;
    logic [CNT_W+1:0]  isr_sum, osr_sum;
    logic [DATA_W-1:0] mask, in_bits, isr_shift, osr_shift, out_val;
    logic              act;

    assign act    = en && !reset;
    assign n      = (cmd_count == '0) ? FULL : {1'b0, cmd_count};
    assign t_push = (cfg_push_thresh == '0) ? FULL : {1'b0, cfg_push_thresh};
    assign t_pull = (cfg_pull_thresh == '0) ? FULL : {1'b0, cfg_pull_thresh};

    // a shift by the full width yields zero, so the mask becomes all ones for n == DATA_W
    assign mask    = ~({DATA_W{1'b1}} << n);
    assign in_bits = in_data & mask;

    assign isr_shift = cfg_in_right ? ((isr_q >> n) | (in_bits << (FULL - n)))
                                    : ((isr_q << n) | in_bits);
    assign osr_shift = cfg_out_right ? (osr_q >> n) : (osr_q << n);
    assign out_val   = cfg_out_right ? (osr_q & mask) : (osr_q >> (FULL - n));

    assign isr_sum     = {1'b0, isr_cnt_q} + {1'b0, n};
    assign osr_sum     = {1'b0, osr_cnt_q} + {1'b0, n};
    assign isr_cnt_inc = (isr_sum > {1'b0, FULL}) ? FULL : isr_sum[CNT_W:0];
    assign osr_cnt_inc = (osr_sum > {1'b0, FULL}) ? FULL : osr_sum[CNT_W:0];

    always_comb begin
        isr_d     = isr_q;
        isr_cnt_d = isr_cnt_q;
        osr_d     = osr_q;
        osr_cnt_d = osr_cnt_q;
        rx_valid  = 1'b0;
        rx_data   = isr_q;
        tx_ready  = 1'b0;
        stall     = 1'b0;
        out_data  = '0;
        if (act) begin
            case (cmd)
                CMD_IN: begin
                    if (cfg_autopush && isr_cnt_q >= t_push) begin
                        stall    = 1'b1;
                        rx_valid = 1'b1;
                        if (rx_ready) begin
                            isr_d     = '0;
                            isr_cnt_d = '0;
                        end
                    end else begin
                        isr_d     = isr_shift;
                        isr_cnt_d = isr_cnt_inc;
                        if (cfg_autopush && isr_cnt_inc >= t_push) begin
                            rx_valid = 1'b1;
                            rx_data  = isr_shift;
                            if (rx_ready) begin
                                isr_d     = '0;
                                isr_cnt_d = '0;
                            end
                        end
                    end
                end
                CMD_OUT: begin
                    if (cfg_autopull && osr_cnt_q >= t_pull) begin
                        stall = 1'b1;
                        if (tx_valid) begin
                            tx_ready  = 1'b1;
                            osr_d     = tx_data;
                            osr_cnt_d = '0;
                        end
                    end else begin
                        out_data  = out_val;
                        osr_d     = osr_shift;
                        osr_cnt_d = osr_cnt_inc;
                        if (cfg_autopull && osr_cnt_inc >= t_pull && tx_valid) begin
                            tx_ready  = 1'b1;
                            osr_d     = tx_data;
                            osr_cnt_d = '0;
                        end
                    end
                end
                CMD_PUSH: begin
                    if (!(cmd_cond && isr_cnt_q < t_push)) begin
                        rx_valid = 1'b1;
                        if (rx_ready || !cmd_block) begin
                            isr_d     = '0;
                            isr_cnt_d = '0;
                        end else begin
                            stall = 1'b1;
                        end
                    end
                end
                CMD_PULL: begin
                    if (!(cmd_cond && osr_cnt_q < t_pull)) begin
                        if (tx_valid) begin
                            tx_ready  = 1'b1;
                            osr_d     = tx_data;
                            osr_cnt_d = '0;
                        end else if (cmd_block) begin
                            stall = 1'b1;
                        end else begin
                            osr_d     = x_in;
                            osr_cnt_d = '0;
                        end
                    end
                end
`ifdef PIO_SHIFT_MOV_EN
                CMD_MOV_ISR: begin
                    isr_d     = in_data;
                    isr_cnt_d = '0;
                end
                CMD_MOV_OSR: begin
                    osr_d     = in_data;
                    osr_cnt_d = '0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isr_q     <= '0;
            isr_cnt_q <= '0;
            osr_q     <= '0;
            osr_cnt_q <= FULL;
        end else begin
            isr_q     <= isr_d;
            isr_cnt_q <= isr_cnt_d;
            osr_q     <= osr_d;
            osr_cnt_q <= osr_cnt_d;
        end
    end

    assign isr       = isr_q;
    assign osr       = osr_q;
    assign isr_count = isr_cnt_q;
    assign osr_count = osr_cnt_q;

endmodule

// File: tb/tb_pio_shift_engine.sv
// Bench for pio_shift_engine (DATA_W=32): directed scenarios plus random
// commands checked every cycle against an arithmetic reference model.
module tb_pio_shift_engine;

    logic        clk = 1'b0;
    logic        reset, en;
    logic [2:0]  cmd;
    logic [4:0]  cmd_count;
    logic        cmd_block, cmd_cond;
    logic [31:0] in_data, x_in;
    logic        cfg_in_right, cfg_out_right, cfg_autopush, cfg_autopull;
    logic [4:0]  cfg_push_thresh, cfg_pull_thresh;
    logic [31:0] rx_data, tx_data, out_data, isr, osr;
    logic        rx_valid, rx_ready, tx_valid, tx_ready, stall;
    logic [5:0]  isr_count, osr_count;

    int total = 0;
    int bad = 0;

    longint m_isr, m_osr, n_isr, n_osr, e_rxd, e_out;
    int     m_ic, m_oc, n_ic, n_oc;
    bit     e_stall, e_rxv, e_txr, e_chk_out;
    logic        o_stall, o_rxv, o_txr;
    logic [31:0] o_rxd, o_out;

    pio_shift_engine #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .en(en), .cmd(cmd), .cmd_count(cmd_count),
        .cmd_block(cmd_block), .cmd_cond(cmd_cond), .in_data(in_data), .x_in(x_in),
        .cfg_in_right(cfg_in_right), .cfg_out_right(cfg_out_right),
        .cfg_autopush(cfg_autopush), .cfg_autopull(cfg_autopull),
        .cfg_push_thresh(cfg_push_thresh), .cfg_pull_thresh(cfg_pull_thresh),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .out_data(out_data), .stall(stall), .isr(isr), .osr(osr),
        .isr_count(isr_count), .osr_count(osr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint p2(int k);
        return longint'(1) << k;
    endfunction

    function automatic int sat(int v);
        return (v > 32) ? 32 : v;
    endfunction

    task automatic predict();
        int n, tp, tl, c;
        longint sh, din;
        n   = (cmd_count == 0) ? 32 : int'(cmd_count);
        tp  = (cfg_push_thresh == 0) ? 32 : int'(cfg_push_thresh);
        tl  = (cfg_pull_thresh == 0) ? 32 : int'(cfg_pull_thresh);
        din = longint'(in_data);
        n_isr = m_isr; n_osr = m_osr; n_ic = m_ic; n_oc = m_oc;
        e_stall = 0; e_rxv = 0; e_txr = 0; e_chk_out = 0; e_rxd = 0; e_out = 0;
        if (reset) begin
            n_isr = 0; n_osr = 0; n_ic = 0; n_oc = 32;
        end else if (en) begin
            case (cmd)
                3'd1: begin
                    if (cfg_autopush && m_ic >= tp) begin
                        e_stall = 1; e_rxv = 1; e_rxd = m_isr;
                        if (rx_ready) begin n_isr = 0; n_ic = 0; end
                    end else begin
                        if (cfg_in_right)
                            sh = m_isr / p2(n) + (din % p2(n)) * p2(32 - n);
                        else
                            sh = (m_isr % p2(32 - n)) * p2(n) + din % p2(n);
                        c = sat(m_ic + n);
                        n_isr = sh; n_ic = c;
                        if (cfg_autopush && c >= tp) begin
                            e_rxv = 1; e_rxd = sh;
                            if (rx_ready) begin n_isr = 0; n_ic = 0; end
                        end
                    end
                end
                3'd2: begin
                    if (cfg_autopull && m_oc >= tl) begin
                        e_stall = 1;
                        if (tx_valid) begin
                            e_txr = 1; n_osr = longint'(tx_data); n_oc = 0;
                        end
                    end else begin
                        e_chk_out = 1;
                        if (cfg_out_right) begin
                            e_out = m_osr % p2(n);
                            n_osr = m_osr / p2(n);
                        end else begin
                            e_out = m_osr / p2(32 - n);
                            n_osr = (m_osr % p2(32 - n)) * p2(n);
                        end
                        n_oc = sat(m_oc + n);
                        if (cfg_autopull && n_oc >= tl && tx_valid) begin
                            e_txr = 1; n_osr = longint'(tx_data); n_oc = 0;
                        end
                    end
                end
                3'd3: begin
                    if (!(cmd_cond && m_ic < tp)) begin
                        e_rxv = 1; e_rxd = m_isr;
                        if (rx_ready || !cmd_block) begin n_isr = 0; n_ic = 0; end
                        else e_stall = 1;
                    end
                end
                3'd4: begin
                    if (!(cmd_cond && m_oc < tl)) begin
                        if (tx_valid) begin
                            e_txr = 1; n_osr = longint'(tx_data); n_oc = 0;
                        end else if (cmd_block) begin
                            e_stall = 1;
                        end else begin
                            n_osr = longint'(x_in); n_oc = 0;
                        end
                    end
                end
`ifdef PIO_SHIFT_MOV_EN
                3'd5: begin n_isr = din; n_ic = 0; end
                3'd6: begin n_osr = din; n_oc = 0; end
`endif
                default: ;
            endcase
        end
    endtask

    task automatic step();
        predict();
        @(negedge clk);
        o_stall = stall; o_rxv = rx_valid; o_txr = tx_ready;
        o_rxd = rx_data; o_out = out_data;
        chk("stall", stall, e_stall);
        chk("rx_valid", rx_valid, e_rxv);
        chk("tx_ready", tx_ready, e_txr);
        if (e_rxv) chk("rx_data", rx_data, e_rxd);
        if (e_chk_out) chk("out_data", out_data, e_out);
        @(posedge clk);
        #1;
        m_isr = n_isr; m_osr = n_osr; m_ic = n_ic; m_oc = n_oc;
        chk("isr", isr, m_isr);
        chk("osr", osr, m_osr);
        chk("isr_count", isr_count, m_ic);
        chk("osr_count", osr_count, m_oc);
    endtask

    task automatic quiet();
        reset = 0; en = 1; cmd = 0; cmd_count = 0; cmd_block = 0; cmd_cond = 0;
        in_data = 0; x_in = 0; cfg_in_right = 0; cfg_out_right = 0;
        cfg_autopush = 0; cfg_autopull = 0; cfg_push_thresh = 0; cfg_pull_thresh = 0;
        rx_ready = 0; tx_data = 0; tx_valid = 0;
    endtask

    initial begin
        logic [7:0] bytes [4];
        bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
        m_isr = 0; m_osr = 0; m_ic = 0; m_oc = 32;
        quiet();
        reset = 1;
        step();
        chk("rst_isr", isr, 0);
        chk("rst_osr", osr, 0);
        chk("rst_isr_cnt", isr_count, 0);
        chk("rst_osr_cnt", osr_count, 32);
        reset = 0;

        cfg_autopush = 1; rx_ready = 1; cmd = 3'd1; cmd_count = 8;
        for (int i = 0; i < 4; i++) begin
            in_data = {24'h0, bytes[i]};
            step();
        end
        chk("t1_rxv", o_rxv, 1);
        chk("t1_push", o_rxd, 32'hA1B2C3D4);
        chk("t1_cnt", isr_count, 0);

        cfg_autopush = 0; rx_ready = 0;
        cfg_autopull = 1; cfg_out_right = 1; tx_data = 32'h12345678; tx_valid = 1;
        cmd = 3'd2; cmd_count = 4;
        step();
        chk("t2_load_stall", o_stall, 1);
        chk("t2_load_txr", o_txr, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t2_out", o_out, 32'(8 - i));
        end
        chk("t2_refill", o_txr, 1);
        chk("t2_refill_cnt", osr_count, 0);

        cfg_autopull = 0; tx_valid = 0; tx_data = 32'hCAFEF00D;
        cmd = 3'd4; cmd_block = 1; cmd_cond = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_stall", o_stall, 1);
        end
        tx_valid = 1;
        step();
        chk("t3_stall_end", o_stall, 0);
        chk("t3_osr", osr, 32'hCAFEF00D);
        chk("t3_cnt", osr_count, 0);

        tx_valid = 0; cmd_block = 0; x_in = 32'hDEADBEEF;
        step();
        chk("t4_stall", o_stall, 0);
        chk("t4_osr", osr, 32'hDEADBEEF);
        cmd = 3'd1; cmd_count = 8; in_data = 32'h55;
        step();
        cmd = 3'd3; cmd_cond = 1; cmd_block = 1; rx_ready = 1;
        step();
        chk("t4_nop_rxv", o_rxv, 0);
        chk("t4_nop_cnt", isr_count, 8);

        quiet();
        reset = 1;
        step();
        reset = 0;
        cfg_autopush = 1; cmd = 3'd1; cmd_count = 0; in_data = 32'h11111111;
        step();
        chk("t5_first_rxv", o_rxv, 1);
        chk("t5_first_stall", o_stall, 0);
        in_data = 32'h22222222;
        step();
        chk("t5_stall", o_stall, 1);
        chk("t5_held", o_rxd, 32'h11111111);
        rx_ready = 1;
        step();
        chk("t5_push_stall", o_stall, 1);
        chk("t5_push", o_rxd, 32'h11111111);
        step();
        chk("t5_retry_stall", o_stall, 0);
        chk("t5_retry", o_rxd, 32'h22222222);
        chk("t5_cnt", isr_count, 0);

        quiet();
        cmd = 3'd4; cmd_block = 1;
        step();
        chk("t6_stall", o_stall, 1);
        reset = 1; tx_valid = 1;
        step();
        chk("t6_rst_stall", o_stall, 0);
        chk("t6_rst_txr", o_txr, 0);
        chk("t6_rst_cnt", osr_count, 32);
        reset = 0; tx_valid = 0;
        cmd = 3'd6; in_data = 32'h5A;
        step();
`ifdef PIO_SHIFT_MOV_EN
        chk("t6_mov", osr, 32'h5A);
        chk("t6_mov_cnt", osr_count, 0);
`else
        chk("t6_mov_nop", osr, 0);
        chk("t6_mov_nop_cnt", osr_count, 32);
`endif

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(63) == 0);
            en = ($urandom_range(3) != 0);
            cmd = 3'($urandom_range(7));
            cmd_count = 5'($urandom);
            cmd_block = 1'($urandom);
            cmd_cond = 1'($urandom);
            in_data = $urandom;
            x_in = $urandom;
            tx_data = $urandom;
            tx_valid = 1'($urandom);
            rx_ready = 1'($urandom);
            if ($urandom_range(15) == 0) begin
                cfg_in_right = 1'($urandom);
                cfg_out_right = 1'($urandom);
                cfg_autopush = 1'($urandom);
                cfg_autopull = 1'($urandom);
                cfg_push_thresh = 5'($urandom);
                cfg_pull_thresh = 5'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
